toggle_req_gen: RTL and testbench
=================================

# toggle_req_gen

Upstream stage of the T flip-flop. Turns a raw, asynchronous, bouncy push-button level into a clean single-cycle toggle request `T` for the flip-flop's `T` input. Internally it:

- synchronises the input,
- debounces it with a consecutive-sample counter and a 4-state FSM,
- emits exactly one `T` pulse per accepted press,
- keeps a wrapping count of emitted pulses for debug.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised samples that must differ from the committed level before a change is accepted. Legal range is 2..255.
- `CNT_W`, default 8: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `btn_in`, input, 1: raw button level, asynchronous to `clk`, may bounce.
- `T`, output, 1: registered one-cycle toggle request; connects to the flip-flop's `T`.
- `btn_level`, output, 1: registered debounced button level.
- `busy`, output, 1: high while the FSM is in WAIT_HIGH or WAIT_LOW.
- `toggle_cnt`, output, 8: number of `T` pulses emitted, modulo 256.

## Operation
**Synchroniser**
- Two flops: `sync0 <= btn_in`, `sync1 <= sync0`.
- Only `sync1` is used downstream.

**FSM states**
- IDLE: committed low.
- WAIT_HIGH: candidate high.
- HIGH: committed high.
- WAIT_LOW: candidate low.

**Transitions** (evaluated each rising edge, `rst` low)
- IDLE: if `sync1`=1, go to WAIT_HIGH with `cnt`<=1. Otherwise stay, `cnt`<=0.
- WAIT_HIGH:
  - `sync1`=0: return to IDLE, `cnt`<=0. This is a bounce and emits no pulse.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: go to HIGH, `btn_level`<=1, `T`<=1, `toggle_cnt`<=`toggle_cnt`+1, `cnt`<=0.
  - Else: `cnt`<=`cnt`+1.
- HIGH: if `sync1`=0, go to WAIT_LOW with `cnt`<=1. Otherwise stay.
- WAIT_LOW:
  - `sync1`=1: return to HIGH, `cnt`<=0.
  - Else if `cnt`==DEBOUNCE_CYCLES-1: go to IDLE, `btn_level`<=0, `cnt`<=0. No pulse on release.
  - Else: `cnt`<=`cnt`+1.

**Output rules**
- `T` is 0 on every cycle other than the one following the WAIT_HIGH→HIGH edge. It is never high on two consecutive cycles.
- `toggle_cnt` wraps from 255 to 0 with no flag.
- `busy` is decoded combinationally from the state register.
- Unused state encodings must recover to IDLE on the next edge.

## Timing
**Reset values** (`rst` sampled high at an edge): `sync0`=0, `sync1`=0, state=IDLE, `cnt`=0, `T`=0, `btn_level`=0, `toggle_cnt`=0, so `busy`=0.

**Reset priority**
- `rst` overrides every transition, including mid-count in WAIT_HIGH or WAIT_LOW.
- A press in progress during reset is discarded and no pulse is emitted.

**Press latency**
- `btn_in` rises before edge 1 and stays stable.
- `sync1`=1 after edge 2. WAIT_HIGH is entered at edge 3.
- HIGH is entered at edge DEBOUNCE_CYCLES+2, with `T`=1 for exactly that one cycle.

**Release latency**
- Symmetric: `btn_level` falls at edge DEBOUNCE_CYCLES+2 after `btn_in` falls.

**Glitch filtering**
- Any `sync1` glitch shorter than DEBOUNCE_CYCLES-1 samples during a WAIT state restarts qualification from the committed state.
- The glitch never produces a pulse.

**Boundary case**
- Minimum `DEBOUNCE_CYCLES`=2 gives a 4-edge press latency.

## Test plan
1. `rst`=1 for 2 cycles, with `btn_in` held at 1 throughout → `T`=0, `btn_level`=0, `toggle_cnt`=0, `busy`=0 during reset.
2. `DEBOUNCE_CYCLES`=4; clean press, `btn_in` 0→1 held 20 cycles → `busy`=1 from edge 3, `T`=1 only after edge 6, then `btn_level`=1 and `toggle_cnt`=1.
3. Bounce: `btn_in` pattern 1,0,1,1,0 per cycle, then 0 → no `T`, `btn_level` stays 0, FSM ends in IDLE.
4. Release bounce: from HIGH, `btn_in` 0 for 2 cycles then 1 → returns to HIGH, `btn_level` stays 1, no `T`. Then a clean release gives `btn_level`=0 at edge 6 with still no `T`.
5. `rst` asserted while in WAIT_HIGH with `cnt`=2 → next cycle IDLE, `cnt`=0, no `T`. After `rst` drops with `btn_in` still 1, a full latency of 6 edges elapses before `T`.
6. Drive 257 clean press/release pairs → 257 single-cycle `T` pulses, `toggle_cnt`=1 after wrap. With the flip-flop attached, Q ends at 1.

Source files
------------

// File: rtl/toggle_req_gen_if.sv
// Bundle of the button-side and toggle-request signals of toggle_req_gen.
// master: the request generator (drives the outputs, reads the raw button).
// slave:  the consumer (drives the raw button, reads the outputs).
interface toggle_req_gen_if;
  logic       btn_in;      // raw, asynchronous, bouncy button level
  logic       T;           // one-cycle toggle request for the T flip-flop
  logic       btn_level;   // debounced, committed button level
  logic       busy;        // FSM is qualifying a candidate level change
  logic [7:0] toggle_cnt;  // T pulses emitted, modulo 256

  modport master (
    input  btn_in,
    output T,
    output btn_level,
    output busy,
    output toggle_cnt
  );

  modport slave (
    output btn_in,
    input  T,
    input  btn_level,
    input  busy,
    input  toggle_cnt
  );
endinterface

// File: rtl/toggle_req_gen.sv
// Push-button front end for a T flip-flop: two-flop synchroniser, a
// consecutive-sample debounce counter driven by a 4-state FSM, a single
// registered T pulse per accepted press and a wrapping pulse counter.
// Legal parameters: DEBOUNCE_CYCLES in 2..255 and 2**CNT_W > DEBOUNCE_CYCLES.
module toggle_req_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  toggle_req_gen_if.master io_bus
);

  // State encoding; all four 2-bit codes are used, the default arm still
  // forces IDLE so a corrupted register can never lock the FSM.
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  // Counter value on the sample that completes qualification.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  logic             r_sync0;
  logic             r_sync1;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_t;
  logic             r_btn_level;
  logic [7:0]       r_toggle_cnt;

  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_level_next;
  logic             w_pulse;

  // Two-flop synchroniser; only r_sync1 is allowed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= io_bus.btn_in;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce FSM next-state, counter and pulse decision.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_level_next = r_btn_level;
    w_pulse      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sync1) begin
          w_state_next = S_WAIT_HIGH;
          w_cnt_next   = LP_CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!r_sync1) begin
          // Bounce: fall back to the committed low level, no pulse.
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_next = S_HIGH;
          w_level_next = 1'b1;
          w_pulse      = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + LP_CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!r_sync1) begin
          w_state_next = S_WAIT_LOW;
          w_cnt_next   = LP_CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (r_sync1) begin
          // Release bounce: the button is still committed high.
          w_state_next = S_HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          // Accepted release commits low but never requests a toggle.
          w_state_next = S_IDLE;
          w_level_next = 1'b0;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_level_next = 1'b0;
      end
    endcase
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Registered outputs: T lasts exactly the cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t          <= 1'b0;
      r_btn_level  <= 1'b0;
      r_toggle_cnt <= 8'd0;
    end else begin
      r_t         <= w_pulse;
      r_btn_level <= w_level_next;
      if (w_pulse) begin
        r_toggle_cnt <= r_toggle_cnt + 8'd1;
      end
    end
  end

  assign io_bus.T          = r_t;
  assign io_bus.btn_level  = r_btn_level;
  assign io_bus.toggle_cnt = r_toggle_cnt;
  assign io_bus.busy       = (r_state == S_WAIT_HIGH) || (r_state == S_WAIT_LOW);

endmodule

// File: tb/tb_toggle_req_gen.sv
// Testbench for toggle_req_gen with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected (edge number, toggle_cnt) of every T pulse it
// should cause; a negedge monitor pops and checks each pulse the DUT shows.
module tb_toggle_req_gen;
  localparam int D = 4;
  localparam int LAT = D + 2;   // edges from btn_in change to accepting edge

  typedef struct packed {
    int         edge_no;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic t_prev = 1'b0;
  logic q_ff;                   // model of the downstream T flip-flop

  toggle_req_gen_if bus ();

  toggle_req_gen #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    if (rst) q_ff <= 1'b0;
    else if (bus.T) q_ff <= ~q_ff;
  end

  // Monitor: every observed T pulse must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (bus.T === 1'b1) begin
      if (t_prev === 1'b1) begin
        n_vec++;
        n_bad++;
        $display("FAIL t_double: T high on consecutive cycles at edge %0d", edge_cnt);
      end
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL t_unexpected: pulse at edge %0d, none expected", edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (e.edge_no != edge_cnt || e.cnt !== bus.toggle_cnt) begin
          n_bad++;
          $display("FAIL t_pulse: got edge %0d cnt %0d, expected edge %0d cnt %0d",
                   edge_cnt, bus.toggle_cnt, e.edge_no, e.cnt);
        end else begin
          $display("pulse ok: edge %0d toggle_cnt %0d", edge_cnt, bus.toggle_cnt);
        end
      end
    end
    t_prev = bus.T;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end else begin
      $display("check ok: %s = %0h (edge %0d)", name, act, edge_cnt);
    end
  endtask

  task automatic expect_pulse(input int base_edge, input logic [7:0] cnt);
    exp_t e;
    e.edge_no = base_edge + LAT;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  int base;
  logic [7:0] cnt_model;

  initial begin
    // 1. Reset with the button held high: nothing may leak through.
    rst        = 1'b1;
    bus.btn_in = 1'b1;
    tick(1);
    check("rst_T", bus.T, 0);
    check("rst_level", bus.btn_level, 0);
    check("rst_cnt", bus.toggle_cnt, 0);
    check("rst_busy", bus.busy, 0);
    tick(1);
    check("rst2_T", bus.T, 0);
    check("rst2_busy", bus.busy, 0);
    bus.btn_in = 1'b0;
    rst        = 1'b0;
    tick(4);
    check("idle_busy", bus.busy, 0);

    // 2. Clean press held 20 cycles.
    bus.btn_in = 1'b1;
    base = edge_cnt;
    expect_pulse(base, 8'd1);
    tick(2);
    check("press_e2_busy", bus.busy, 0);
    tick(1);
    check("press_e3_busy", bus.busy, 1);
    tick(2);
    check("press_e5_busy", bus.busy, 1);
    check("press_e5_level", bus.btn_level, 0);
    check("press_e5_T", bus.T, 0);
    tick(1);
    check("press_e6_T", bus.T, 1);
    check("press_e6_level", bus.btn_level, 1);
    check("press_e6_cnt", bus.toggle_cnt, 1);
    check("press_e6_busy", bus.busy, 0);
    tick(1);
    check("press_e7_T", bus.T, 0);
    tick(13);
    check("press_hold_level", bus.btn_level, 1);

    // 4. Release bounce from HIGH, then a clean release (no pulse either way).
    bus.btn_in = 1'b0;
    tick(2);
    bus.btn_in = 1'b1;
    tick(8);
    check("relbounce_level", bus.btn_level, 1);
    check("relbounce_busy", bus.busy, 0);
    bus.btn_in = 1'b0;
    tick(5);
    check("release_e5_level", bus.btn_level, 1);
    check("release_e5_busy", bus.busy, 1);
    tick(1);
    check("release_e6_level", bus.btn_level, 0);
    check("release_e6_busy", bus.busy, 0);
    check("release_cnt", bus.toggle_cnt, 1);
    tick(4);

    // 3. Press bounce 1,0,1,1,0 then 0: filtered, ends in IDLE.
    bus.btn_in = 1'b1; tick(1);
    bus.btn_in = 1'b0; tick(1);
    bus.btn_in = 1'b1; tick(1);
    bus.btn_in = 1'b1; tick(1);
    bus.btn_in = 1'b0; tick(1);
    bus.btn_in = 1'b0; tick(10);
    check("bounce_level", bus.btn_level, 0);
    check("bounce_busy", bus.busy, 0);
    check("bounce_cnt", bus.toggle_cnt, 1);

    // 5. Reset mid-qualification in WAIT_HIGH with cnt=2.
    bus.btn_in = 1'b1;
    tick(4);
    check("midrst_busy_before", bus.busy, 1);
    check("midrst_cnt_before", dut.r_cnt, 2);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cnt", dut.r_cnt, 0);
    check("midrst_T", bus.T, 0);
    check("midrst_toggle_cnt", bus.toggle_cnt, 0);
    rst  = 1'b0;
    base = edge_cnt;
    expect_pulse(base, 8'd1);
    tick(5);
    check("postrst_e5_T", bus.T, 0);
    tick(1);
    check("postrst_e6_T", bus.T, 1);
    bus.btn_in = 1'b0;
    tick(10);
    check("postrst_release_level", bus.btn_level, 0);

    // 6. 257 clean press/release pairs from reset: counter wraps to 1, Q ends 1.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    cnt_model = 8'd0;
    for (int i = 0; i < 257; i++) begin
      bus.btn_in = 1'b1;
      base = edge_cnt;
      cnt_model = cnt_model + 8'd1;
      expect_pulse(base, cnt_model);
      tick(LAT + 3);
      bus.btn_in = 1'b0;
      tick(LAT + 3);
    end
    check("wrap_cnt", bus.toggle_cnt, 1);
    check("wrap_q", q_ff, 1);
    tick(3);
    check("pending_pulses", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
